// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding, command bytes and default timing.
package ps2_pkg;

    typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP, ACK} tx_state_t;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ECHO    = 8'hEE;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] BREAK_CODE  = 8'hF0;
    localparam logic [7:0] ACK_CODE    = 8'hFA;

    localparam int DEF_INHIBIT_CYCLES = 20000;
    localparam int DEF_TIMEOUT_CYCLES = 2000000;
    localparam int DEF_FILTER_LEN     = 8;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: debounces the PS/2 clock line and flags its falling edges.
module ps2_clk_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = DEF_FILTER_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c_in,
    output logic fall_edge
);

    logic [FILTER_LEN-1:0] sr, sr_next;
    logic level, level_next;

    always_comb begin
        sr_next    = {ps2c_in, sr[FILTER_LEN-1:1]};
        level_next = &sr_next ? 1'b1 : ~|sr_next ? 1'b0 : level;
        fall_edge  = level & ~level_next;
    end

    // idle line is high, so start from all ones to avoid a spurious edge
    always_ff @(posedge clk) begin
        if (reset) begin
            sr    <= '1;
            level <= 1'b1;
        end else begin
            sr    <= sr_next;
            level <= level_next;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with RTS, parity and ACK check.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_drv_low,
    output logic       ps2d_drv_low,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err_tick
);

    localparam int CW = $clog2((INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES) + 1);

    tx_state_t state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [3:0] bit_cnt, bit_cnt_next;
    logic [8:0] sbuf, sbuf_next;
    logic done_next, err_next, fall_edge, active, timeout;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk(clk),
        .reset(reset),
        .ps2c_in(ps2c_in),
        .fall_edge(fall_edge)
    );

    assign active  = state inside {START, DATA, STOP, ACK};
    assign timeout = active && cnt == CW'(TIMEOUT_CYCLES - 1);

    always_comb begin
        state_next   = state;
        cnt_next     = active ? cnt + CW'(1) : cnt;
        bit_cnt_next = bit_cnt;
        sbuf_next    = sbuf;
        done_next    = 1'b0;
        err_next     = 1'b0;
        case (state)
            IDLE:
                if (wr_ps2) begin
                    sbuf_next    = {odd_parity(din), din};
                    bit_cnt_next = '0;
                    cnt_next     = '0;
                    state_next   = RTS;
                end
            RTS: begin
                cnt_next = cnt + CW'(1);
                if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
                    cnt_next   = '0;
                    state_next = START;
                end
            end
            START:
                if (fall_edge) state_next = DATA;
            DATA:
                if (fall_edge) begin
                    sbuf_next    = {1'b1, sbuf[8:1]};
                    bit_cnt_next = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd8) state_next = STOP;
                end
            STOP:
                if (fall_edge) state_next = ACK;
            ACK:
                if (fall_edge) begin
                    done_next  = ~ps2d_in;
                    err_next   = ps2d_in;
                    state_next = IDLE;
                end
            default: state_next = IDLE;
        endcase
        // a stalled device aborts the frame regardless of progress
        if (timeout) begin
            state_next = IDLE;
            done_next  = 1'b0;
            err_next   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_cnt      <= '0;
            sbuf         <= '0;
            tx_done_tick <= 1'b0;
            tx_err_tick  <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            bit_cnt      <= bit_cnt_next;
            sbuf         <= sbuf_next;
            tx_done_tick <= done_next;
            tx_err_tick  <= err_next;
        end
    end

    always_comb begin
        tx_idle      = state == IDLE;
        ps2c_drv_low = state == RTS;
        ps2d_drv_low = (state == RTS && cnt == CW'(INHIBIT_CYCLES - 1)) || state == START || (state == DATA && !sbuf[0]);
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with an open-drain PS/2 device model.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 200;
    localparam int TO   = 3000;
    localparam int HALF = 30;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic wr_ps2 = 1'b0;
    logic [7:0] din = '0;
    logic dev_c = 1'b1;
    logic dev_d = 1'b1;
    logic ps2c_in, ps2d_in;
    logic ps2c_drv_low, ps2d_drv_low, tx_idle, tx_done_tick, tx_err_tick;
    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    assign ps2c_in = ~ps2c_drv_low & dev_c;
    assign ps2d_in = ~ps2d_drv_low & dev_d;

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(8)) dut (
        .clk(clk),
        .reset(reset),
        .wr_ps2(wr_ps2),
        .din(din),
        .ps2c_in(ps2c_in),
        .ps2d_in(ps2d_in),
        .ps2c_drv_low(ps2c_drv_low),
        .ps2d_drv_low(ps2d_drv_low),
        .tx_idle(tx_idle),
        .tx_done_tick(tx_done_tick),
        .tx_err_tick(tx_err_tick)
    );

    always @(negedge clk) begin
        if (tx_done_tick) done_cnt++;
        if (tx_err_tick) err_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rest(input string tag);
        chk({tag, "_idle"}, tx_idle, 1);
        chk({tag, "_c_drv"}, ps2c_drv_low, 0);
        chk({tag, "_d_drv"}, ps2d_drv_low, 0);
        chk({tag, "_done"}, tx_done_tick, 0);
        chk({tag, "_err"}, tx_err_tick, 0);
    endtask

    task automatic start_rts(input logic [7:0] d);
        int rts;
        wr_ps2 = 1'b1;
        din = d;
        tick(1);
        wr_ps2 = 1'b0;
        din = '0;
        rts = 0;
        while (ps2c_drv_low && rts < INH + 10) begin
            rts++;
            tick(1);
        end
        chk("rts_len", rts, INH);
        chk("start_bit_drv", ps2d_drv_low, 1);
    endtask

    // mode 0: plain frame, 1: extra wr_ps2 mid-DATA, 2: reset mid-DATA
    task automatic frame(input logic [7:0] d, input logic nack, input int mode);
        logic [10:0] got;
        int d0, e0;
        got = '0;
        d0 = done_cnt;
        e0 = err_cnt;
        start_rts(d);
        tick(HALF);
        for (int k = 1; k <= 12; k++) begin
            if (k == 12) dev_d = nack;
            else got[k-1] = ps2d_in;
            dev_c = 1'b0;
            tick(HALF);
            if (k == 12) dev_d = 1'b1;
            dev_c = 1'b1;
            tick(HALF);
            if (mode == 1 && k == 4) begin
                wr_ps2 = 1'b1;
                din = 8'h00;
                tick(1);
                wr_ps2 = 1'b0;
            end
            if (mode == 2 && k == 5) begin
                reset = 1'b1;
                tick(1);
                reset = 1'b0;
                chk_rest("mid_reset");
                tick(HALF * 4);
                chk("mid_reset_no_done", done_cnt - d0, 0);
                chk("mid_reset_no_err", err_cnt - e0, 0);
                return;
            end
        end
        chk("frame_bits", got, {1'b1, ~^d, d, 1'b0});
        chk("done_count", done_cnt - d0, nack ? 0 : 1);
        chk("err_count", err_cnt - e0, nack ? 1 : 0);
        chk("end_idle", tx_idle, 1);
    endtask

    initial begin
        int c, e0;
        tick(2);
        chk_rest("reset");
        reset = 1'b0;
        tick(20);
        chk_rest("hold");

        frame(CMD_SET_LED, 1'b0, 0);
        frame(8'h01, 1'b0, 0);
        frame(8'hFF, 1'b0, 0);
        frame(8'h00, 1'b0, 0);
        frame(CMD_SET_LED, 1'b1, 0);
        frame(CMD_SET_LED, 1'b0, 1);
        frame(CMD_RESET, 1'b0, 2);

        e0 = err_cnt;
        start_rts(CMD_ECHO);
        c = 0;
        while (!tx_err_tick && c < TO + 10) begin
            tick(1);
            c++;
        end
        chk("timeout_len", c, TO);
        chk("timeout_c_drv", ps2c_drv_low, 0);
        chk("timeout_d_drv", ps2d_drv_low, 0);
        chk("timeout_idle", tx_idle, 1);
        chk("timeout_no_done", tx_done_tick, 0);
        tick(1);
        chk("timeout_err_width", err_cnt - e0, 1);

        wr_ps2 = 1'b1;
        reset = 1'b1;
        din = CMD_ECHO;
        tick(1);
        wr_ps2 = 1'b0;
        reset = 1'b0;
        chk_rest("wr_and_reset");
        tick(2);
        chk_rest("wr_and_reset_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
